unified_mem_arbiter: RTL

- Arbitrates the single-port unified instruction/data memory between two requesters: the fetch stage (IF) and the load/store stage (DM).
- Issues one registered memory command per cycle and routes read data back to the requester that issued the read.
- Data accesses have priority. A starvation counter guarantees fetch forward progress.
- A halt input freezes new grants while reads already in flight complete.

---
 rtl/unified_mem_arbiter_if.sv | 42 ++++
 rtl/unified_mem_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Requester and memory-side signals of the unified memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              halt_in;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, halt_in, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, halt_in, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between fetch (IF) and load/store (DM), DM first with IF anti-starvation.
// Defining ARB_PERF_CNT_EN adds the if_stall_cnt / dm_grant_cnt performance counters.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk1,
  input  logic reset,
  unified_mem_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0] if_stall_cnt,
  output logic [15:0] dm_grant_cnt
`endif
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_DM   = 2'd2
  } tag_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  tag_t       rsp_tag;
  logic       if_wins;
  logic       grant_any;

  // IF beats DM only when DM is idle or IF has been starved long enough
  assign if_wins    = bus.if_req && (!bus.dm_req || starve_cnt == STARVE_LIM);
  assign bus.if_gnt = !bus.halt_in && if_wins;
  assign bus.dm_gnt = !bus.halt_in && bus.dm_req && !if_wins;
  assign grant_any  = bus.if_gnt || bus.dm_gnt;

  assign bus.if_rdata = bus.mem_rdata;
  assign bus.dm_rdata = bus.mem_rdata;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || bus.if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      rsp_tag       <= TAG_NONE;
    end else begin
      bus.mem_en <= grant_any;
      bus.mem_we <= bus.dm_gnt && bus.dm_we;
      if (bus.dm_gnt) begin
        bus.mem_addr  <= bus.dm_addr;
        bus.mem_wdata <= bus.dm_wdata;
      end else if (bus.if_gnt) begin
        bus.mem_addr  <= bus.if_addr;
        bus.mem_wdata <= '0;
      end
      if (bus.dm_gnt && !bus.dm_we) begin
        rsp_tag <= TAG_DM;
      end else if (bus.if_gnt) begin
        rsp_tag <= TAG_IF;
      end else begin
        rsp_tag <= TAG_NONE;
      end
    end
  end

  // The tag rides one stage behind the command so rvalid lines up with mem_rdata
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      bus.if_rvalid <= 1'b0;
      bus.dm_rvalid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_rvalid <= (rsp_tag == TAG_IF);
      bus.dm_rvalid <= (rsp_tag == TAG_DM);
      bus.busy      <= grant_any || (rsp_tag != TAG_NONE);
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      if_stall_cnt <= '0;
      dm_grant_cnt <= '0;
    end else begin
      if (bus.if_req && !bus.if_gnt && if_stall_cnt != 16'hFFFF) begin
        if_stall_cnt <= if_stall_cnt + 16'd1;
      end
      if (bus.dm_gnt && dm_grant_cnt != 16'hFFFF) begin
        dm_grant_cnt <= dm_grant_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
